sram_mem_ctrl: RTL and testbench
================================

# sram_mem_ctrl

Multi-cycle controller that sequences 32-bit data-memory accesses from the MEM stage of the 5-stage ARM pipeline onto an external 16-bit-wide synchronous-interface SRAM. It splits each word access into two halfword phases, drives the SRAM address, data and write-strobe pins, and reassembles read data. Its `ready` output is low while an access is in flight; the top level uses `~ready` as the global pipeline freeze, so all pipeline registers, including the MEM→WB register, hold.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 2: cycles per halfword phase, ≥1.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: MEM-stage store request; held stable while `ready`=0.
- `rd_en` in 1: MEM-stage load request; held stable while `ready`=0.
- `address` in 32: byte address from ALU result.
- `write_data` in 32: store data (Val_Rm).
- `read_data` out 32: assembled load data, registered.
- `ready` out 1: 1 = no access pending or access completing this cycle.
- `sram_addr` out 18: SRAM halfword address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: 1 = controller drives the DQ bus (top-level tristate).
- `sram_dq_in` in 16: SRAM read data.
- `sram_we_n` out 1: active-low write strobe.

## Operation
- States:
  - IDLE: no access in flight.
  - LO: low-halfword phase.
  - HI: high-halfword phase.
  - DONE: completion cycle.
- A 2-bit mode flag (read/write) is latched at acceptance.
- Address map:
  - word = (`address` − `ADDR_BASE`) >> 2, truncated to 17 bits (modulo wrap, no range error).
  - `sram_addr` = {word, 0} in LO and {word, 1} in HI.
  - Low halfword sits at the even address.
- IDLE behaviour:
  - If `wr_en` or `rd_en` is high: latch word address and `write_data`, set mode, go to LO, clear the phase counter.
  - If both are high, write has priority.
- LO and HI each last exactly `WAIT_CYCLES` cycles, timed by the phase counter (0..WAIT_CYCLES−1).
  - LO → HI when the counter reaches the terminal count.
  - HI → DONE when the counter reaches the terminal count.
- Write phases:
  - `sram_dq_oe`=1 and `sram_we_n`=0 for every cycle of LO and HI.
  - `sram_dq_out` = latched data[15:0] in LO, data[31:16] in HI.
- Read phases:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - On the terminal cycle of LO, `sram_dq_in` is captured into `read_data[15:0]`.
  - On the terminal cycle of HI, it is captured into `read_data[31:16]`.
- `read_data` holds its value until the next read overwrites it. Writes never alter it.
- DONE:
  - `ready`=1 for exactly one cycle, then IDLE unconditionally.
  - The still-asserted request is not re-accepted in DONE.
- `ready` is combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise. In particular it is 0 in the IDLE cycle a request first appears, so the freeze takes effect immediately.
- Outside write phases: `sram_we_n`=1, `sram_dq_oe`=0, `sram_dq_out`=0.
- `sram_addr` holds its last value when idle.

## Timing
- Reset values: state IDLE, `read_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1, `ready`=1 (with no request).
- Cycle numbering: cycle 0 is the first IDLE cycle with a request.
  - LO occupies cycles 1..W.
  - HI occupies cycles W+1..2W.
  - DONE is cycle 2W+1.
  - W = `WAIT_CYCLES`.
- Freeze length is 2W+1 cycles (`ready`=0 in cycles 0..2W). The pipeline advances at the end of cycle 2W+1.
- Read data is valid in `read_data` from cycle 2W+1 onward and is sampled by the MEM→WB register at that edge.
- Back-to-back accesses: the next request is accepted in the IDLE cycle immediately after DONE. Minimum spacing is 2W+2 cycles.
- Reset mid-access takes effect at the next edge:
  - State returns to IDLE, `sram_we_n`=1, `sram_dq_oe`=0.
  - The partial write is not completed.
  - `read_data` is cleared to 0.
- `sram_*` outputs are registered, or decoded from registered state only. They are glitch-free relative to `clk`.

## Test plan
Benches use W=2 and ADDR_BASE=1024.

- After reset, no request:
  - `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `read_data`=0.
- Write 0xDEADBEEF at `address`=1028:
  - Cycles 1–2: `sram_addr`=2, `sram_dq_out`=0xBEEF, `sram_we_n`=0.
  - Cycles 3–4: `sram_addr`=3, `sram_dq_out`=0xDEAD, `sram_we_n`=0.
  - `ready`=0 in cycles 0–4, `ready`=1 only in cycle 5.
- Read at 1028 with the SRAM model holding [2]=0xBEEF, [3]=0xDEAD:
  - `read_data`=0xDEADBEEF in cycle 5.
  - `sram_we_n`=1 and `sram_dq_oe`=0 throughout.
- Back-to-back: write 0x12345678 at 1032, then read at 1032 with requests held until `ready`:
  - Read accepted in cycle 6.
  - `read_data`=0x12345678 in cycle 11.
  - `sram_addr` sequence 4,4,5,5 for each access.
- `rst` asserted in cycle 2 of a write to 1024:
  - Next cycle: `sram_we_n`=1, `sram_dq_oe`=0, `ready`=1 (requests low).
  - A following read restarts from LO with a full 5-cycle freeze.
- `wr_en`=`rd_en`=1, `address`=1024, data 0xA5A5_5A5A:
  - Write performed (0x5A5A then 0xA5A5 on DQ, `sram_we_n`=0).
  - `read_data` unchanged.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// Multi-cycle controller mapping 32-bit MEM-stage accesses onto a 16-bit synchronous SRAM.
// Each word is moved as two halfword phases; ready low freezes the pipeline meanwhile.
module sram_mem_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    mode;
  logic [16:0]   word;
  logic [31:0]   data_q;
  logic          req;
  logic          term;
  logic [16:0]   word_next;

  assign req       = wr_en | rd_en;
  assign term      = (cnt == TERM);
  assign word_next = 17'((address - ADDR_BASE) >> 2);
  assign ready     = ((state == S_IDLE) && !req) || (state == S_DONE);

  // SRAM pins are registered, so each phase's pin values are loaded on the
  // edge that enters that phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mode        <= MODE_NONE;
      word        <= '0;
      data_q      <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            mode        <= wr_en ? MODE_WR : MODE_RD;
            word        <= word_next;
            data_q      <= write_data;
            cnt         <= '0;
            state       <= S_LO;
            sram_addr   <= {word_next, 1'b0};
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
            sram_dq_out <= wr_en ? write_data[15:0] : '0;
          end
        end
        S_LO: begin
          if (mode == MODE_WR)
            sram_dq_out <= term ? data_q[31:16] : data_q[15:0];
          if (term) begin
            cnt       <= '0;
            state     <= S_HI;
            sram_addr <= {word, 1'b1};
            if (mode == MODE_RD)
              read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HI: begin
          if (term) begin
            cnt         <= '0;
            state       <= S_DONE;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_dq_out <= '0;
            if (mode == MODE_RD)
              read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          mode  <= MODE_NONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Self-checking bench for sram_mem_ctrl: halfword SRAM model on the pins,
// word-level reference memory for expected load data.
module tb_sram_mem_ctrl;

  localparam int W = 2;
  localparam int NWORDS = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  sram_mem_ctrl #(.ADDR_BASE(32'd1024), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Halfword SRAM: combinational read, write on the edge while we_n is low.
  logic [15:0] sram_mem [0:2*NWORDS-1];
  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

  // Word-level reference contents and expected load register.
  logic [31:0] ref_word [0:NWORDS-1];
  logic [31:0] exp_rd;
  logic [17:0] last_addr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - 32'd1024) / 4);
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
    check_eq({tag, "_oe"}, 32'(sram_dq_oe), 32'd0);
    check_eq({tag, "_dq"}, 32'(sram_dq_out), 32'd0);
    check_eq({tag, "_addr"}, 32'(sram_addr), 32'(last_addr));
    check_eq({tag, "_rdata"}, read_data, exp_rd);
  endtask

  // Present a request in the current idle cycle (cycle 0) and follow it to DONE.
  // The request stays asserted through DONE; the caller decides what comes next.
  task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] data);
    logic [16:0] w;
    logic        is_wr;
    logic [15:0] half;
    w     = word_of(addr);
    is_wr = wr;
    @(negedge clk);
    wr_en = wr; rd_en = rd; address = addr; write_data = data;
    #1;
    check_eq("ready_c0", 32'(ready), 32'd0);
    for (int k = 1; k <= 2 * W; k++) begin
      @(negedge clk); #1;
      half = (k > W) ? data[31:16] : data[15:0];
      check_eq("ready_busy", 32'(ready), 32'd0);
      check_eq("sram_addr", 32'(sram_addr), 32'({w, (k > W) ? 1'b1 : 1'b0}));
      check_eq("we_n", 32'(sram_we_n), is_wr ? 32'd0 : 32'd1);
      check_eq("dq_oe", 32'(sram_dq_oe), is_wr ? 32'd1 : 32'd0);
      check_eq("dq_out", 32'(sram_dq_out), is_wr ? 32'(half) : 32'd0);
    end
    if (is_wr) ref_word[w] = data;
    else       exp_rd = ref_word[w];
    last_addr = {w, 1'b1};
    @(negedge clk); #1;
    check_eq("ready_done", 32'(ready), 32'd1);
    check_eq("rdata_done", read_data, exp_rd);
    check_quiet("done");
  endtask

  task automatic go_idle();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    check_eq("ready_idle", 32'(ready), 32'd1);
    check_quiet("idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    int op;

    for (int i = 0; i < NWORDS; i++) begin
      v = $urandom;
      ref_word[i]       = v;
      sram_mem[2*i]     = v[15:0];
      sram_mem[2*i + 1] = v[31:16];
    end
    exp_rd = '0; last_addr = '0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_quiet("rst");

    // Directed write then read of the same word.
    do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF);
    go_idle();
    check_eq("mem2", 32'(sram_mem[2]), 32'h0000BEEF);
    check_eq("mem3", 32'(sram_mem[3]), 32'h0000DEAD);
    do_access(1'b0, 1'b1, 32'd1028, 32'h0);
    check_eq("rd_1028", read_data, 32'hDEADBEEF);
    go_idle();

    // Back-to-back write then read, read accepted right after DONE.
    do_access(1'b1, 1'b0, 32'd1032, 32'h12345678);
    do_access(1'b0, 1'b1, 32'd1032, 32'h0);
    check_eq("rd_b2b", read_data, 32'h12345678);
    go_idle();

    // Simultaneous requests: write wins, read_data untouched.
    do_access(1'b1, 1'b1, 32'd1024, 32'hA5A55A5A);
    go_idle();
    check_eq("prio_lo", 32'(sram_mem[0]), 32'h00005A5A);
    check_eq("prio_hi", 32'(sram_mem[1]), 32'h0000A5A5);

    // Reset during the low phase of a write: only the low half reached SRAM.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1024; write_data = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    ref_word[0][15:0] = 16'hF00D;
    exp_rd = '0; last_addr = '0;
    check_eq("rst_mid_ready", 32'(ready), 32'd1);
    check_quiet("rst_mid");
    do_access(1'b0, 1'b1, 32'd1024, 32'h0);
    check_eq("rd_after_rst", read_data, 32'hA5A5F00D);
    go_idle();

    // Modulo wrap below the base address.
    do_access(1'b1, 1'b0, 32'd1020, 32'hCAFE_0001);
    go_idle();
    check_eq("wrap_addr", 32'(last_addr), 32'h3FFFF);
    do_access(1'b0, 1'b1, 32'd1020, 32'h0);
    go_idle();

    // Randomized mix, sometimes back-to-back.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'd1024 + 4 * $urandom_range(0, 15);
      do_access(op != 1, op != 0, a, $urandom);
      repeat ($urandom_range(0, 2)) go_idle();
    end
    go_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
